// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, the stream-master state encoding
// and the response record handed back on the response stream.
package wb_pkg;

    // Generic Wishbone bus widths used by every initiator and target on this bus
    localparam int WB_ADDRESS_WIDTH = 32;
    localparam int WB_DATA_WIDTH    = 32;

    // Stream-master transaction phases: waiting for a command, running a
    // single classic cycle on the bus, and presenting the response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_master_state_t;

    // Response record: read data (zero for writes and timeouts) and the
    // timeout flag.
    typedef struct packed {
        logic [WB_DATA_WIDTH-1:0] dat;
        logic                     err;
    } wb_rsp_t;

endpackage

// File: rtl/wb_stream_master.sv
// Wishbone initiator that turns a valid/ready command stream into single
// classic Wishbone cycles and returns one response per command. A bus timer
// aborts cycles to unmapped addresses, and a saturating counter records how
// many aborts have happened since reset.
module wb_stream_master
    import wb_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = WB_ADDRESS_WIDTH,
    parameter int DATA_WIDTH        = WB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES    = 1024,
    parameter int TIMEOUT_CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_we,
    input  logic [ADDRESS_WIDTH-1:0]     cmd_adr,
    input  logic [DATA_WIDTH-1:0]        cmd_dat,

    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_WIDTH-1:0]        rsp_dat,
    output logic                         rsp_err,

    output logic [ADDRESS_WIDTH-1:0]     wb_adr,
    output logic [DATA_WIDTH-1:0]        wb_dat_i,
    input  logic [DATA_WIDTH-1:0]        wb_dat_o,
    output logic                         wb_we,
    output logic                         wb_stb,
    output logic                         wb_cyc,
    input  logic                         wb_ack,

    output logic [TIMEOUT_CNT_WIDTH-1:0] timeout_count
);

    // The timer counts stb-high cycles without ack; it only needs to reach
    // TIMEOUT_CYCLES-1, at which point the next ack-less edge aborts.
    localparam int                     TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST  = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    wb_master_state_t               state_q,         state_d;
    logic [ADDRESS_WIDTH-1:0]       wb_adr_q,        wb_adr_d;
    logic [DATA_WIDTH-1:0]          wb_dat_q,        wb_dat_d;
    logic                           wb_we_q,         wb_we_d;
    logic                           wb_active_q,     wb_active_d;
    logic                           rsp_valid_q,     rsp_valid_d;
    wb_rsp_t                        rsp_q,           rsp_d;
    logic [TIMER_WIDTH-1:0]         timer_q,         timer_d;
    logic [TIMEOUT_CNT_WIDTH-1:0]   timeout_count_q, timeout_count_d;

    // Commands are only taken in IDLE, and never while reset is held.
    assign cmd_ready = (state_q == IDLE) & ~rst;

    // Single-access cycles only, so stb and cyc share one register and can
    // never disagree.
    assign wb_adr        = wb_adr_q;
    assign wb_dat_i      = wb_dat_q;
    assign wb_we         = wb_we_q;
    assign wb_stb        = wb_active_q;
    assign wb_cyc        = wb_active_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_dat       = rsp_q.dat;
    assign rsp_err       = rsp_q.err;
    assign timeout_count = timeout_count_q;

    // State and datapath registers; the async reset drops cyc/stb and any
    // pending response immediately, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            wb_adr_q        <= '0;
            wb_dat_q        <= '0;
            wb_we_q         <= 1'b0;
            wb_active_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_q           <= '0;
            timer_q         <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            wb_adr_q        <= wb_adr_d;
            wb_dat_q        <= wb_dat_d;
            wb_we_q         <= wb_we_d;
            wb_active_q     <= wb_active_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_q           <= rsp_d;
            timer_q         <= timer_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    // Next-state and datapath: accept a command in IDLE, run the bus cycle
    // until ack or timeout in BUS, hold the response in RESP until consumed.
    // Ack and command inputs are only looked at in their own state.
    always_comb begin
        state_d         = state_q;
        wb_adr_d        = wb_adr_q;
        wb_dat_d        = wb_dat_q;
        wb_we_d         = wb_we_q;
        wb_active_d     = wb_active_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_d           = rsp_q;
        timer_d         = timer_q;
        timeout_count_d = timeout_count_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    wb_adr_d    = cmd_adr;
                    wb_dat_d    = cmd_dat;
                    wb_we_d     = cmd_we;
                    wb_active_d = 1'b1;
                    timer_d     = '0;
                    state_d     = BUS;
                end
            end

            BUS: begin
                if (wb_ack) begin
                    wb_active_d = 1'b0;
                    wb_we_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_d.err   = 1'b0;
                    rsp_d.dat   = wb_we_q ? '0 : wb_dat_o;
                    state_d     = RESP;
                end else if (timer_q == TIMER_LAST) begin
                    wb_active_d = 1'b0;
                    wb_we_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_d.err   = 1'b1;
                    rsp_d.dat   = '0;
                    if (timeout_count_q != '1) begin
                        timeout_count_d = timeout_count_q + 1'b1;
                    end
                    state_d     = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                wb_active_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/wb_stream_master.md
Name: wb_stream_master

Overview:
Wishbone initiator that converts a valid/ready command stream (host-link register access requests) into single classic Wishbone cycles. It returns one response per command on a valid/ready response stream. It sits upstream of wb_interconnect and drives its slave-side bus. A bus timeout guards against unmapped addresses, which get no ack from the interconnect.

Parameters:
ADDRESS_WIDTH, 32, width of command and Wishbone address
DATA_WIDTH, 32, width of command, response and Wishbone data
TIMEOUT_CYCLES, 1024, maximum stb-high cycles before abort; must be >= 1
TIMEOUT_CNT_WIDTH, 16, width of saturating timeout event counter

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_we  in  1  1=write, 0=read
cmd_adr  in  ADDRESS_WIDTH  byte/word address as used by the interconnect
cmd_dat  in  DATA_WIDTH  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_dat  out  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_err  out  1  1 = timeout
wb_adr  out  ADDRESS_WIDTH  Wishbone address
wb_dat_i  out  DATA_WIDTH  data to slaves
wb_dat_o  in  DATA_WIDTH  data from slaves
wb_we  out  1  write enable
wb_stb  out  1  strobe
wb_cyc  out  1  cycle
wb_ack  in  1  slave acknowledge
timeout_count  out  TIMEOUT_CNT_WIDTH  saturating count of timeouts

Behaviour:
- Reset asserted (async): state IDLE. wb_cyc, wb_stb, wb_we, rsp_valid and rsp_err are 0. wb_adr, wb_dat_i and rsp_dat are 0. timeout_count is 0 and the timer is 0. cmd_ready is forced 0 while rst is high.
- All outputs are registered except cmd_ready = (state==IDLE) & ~rst.
- FSM IDLE:
  - cmd_ready=1.
  - On valid&ready at edge N: latch we/adr/dat onto wb_* and set wb_cyc=wb_stb=1 from N.
  - Clear the timer. Go to BUS.
- FSM BUS:
  - Each edge with wb_ack=1: drop cyc/stb and set we=0. Set rsp_valid=1 and rsp_err=0. rsp_dat = wb_dat_o if read, else 0. Go to RESP.
  - Else the timer increments. On the edge where stb has been high TIMEOUT_CYCLES cycles with no ack: drop cyc/stb, set rsp_valid=1, rsp_err=1, rsp_dat=0. timeout_count increments (saturating at all-ones). Go to RESP.
  - ack sampled on the final timeout edge wins: success, no error.
- FSM RESP:
  - Response held stable while rsp_ready=0.
  - On rsp_valid&rsp_ready: rsp_valid=0, go to IDLE.
- Latency:
  - Zero-wait slave (combinational ack): cmd accepted edge N, stb high one cycle, ack sampled at N+1, rsp_valid high after N+1.
  - With k wait states, stb is high k+1 cycles.
  - Minimum 3 cycles per transaction.
- wb_adr, wb_dat_i and wb_we are constant while wb_stb=1. stb never drops without cyc dropping (single-access cycles only).
- wb_ack while not in BUS is ignored. This includes a late ack after a timeout and a stray ack in IDLE or RESP.
- cmd_* are ignored unless in IDLE.
- Reset mid-cycle: cyc/stb fall immediately, with no clock edge needed. A pending response is discarded and no response is issued for the aborted command.
- Timer width is $clog2(TIMEOUT_CYCLES+1). No wrap is possible.

Decomposition:
- Package wb_pkg: state enum typedef (IDLE, BUS, RESP) and a response struct typedef {dat, err}. Generic Wishbone constants are shared with other bus users.
- No sub-module. The timer and saturating counter are inline.

Test Plan:
- Write, zero-wait slave: cmd we=1 adr=0x400 dat=0x12345678 -> exactly 1 stb-high cycle with wb_adr=0x400, wb_dat_i=0x12345678, wb_we=1; response rsp_err=0, rsp_dat=0.
- Read, 3 wait states, slave returns 0xCAFEF00D -> cyc/stb high exactly 4 cycles, wb_we=0; rsp_dat=0xCAFEF00D, rsp_err=0.
- Timeout, TIMEOUT_CYCLES=16, no ack -> stb high exactly 16 cycles; rsp_err=1, rsp_dat=0, timeout_count=1. Ack on the 16th cycle instead -> rsp_err=0, timeout_count unchanged. Ack injected 2 cycles after a timeout -> no effect.
- Backpressure: rsp_ready low 10 cycles after response -> rsp_valid/dat/err stable, cmd_ready=0, no new cyc despite cmd_valid=1. Raising rsp_ready -> handshake, cmd_ready=1 next cycle.
- Reset mid-BUS: rst asserted between edges while stb high -> cyc/stb/rsp_valid low before the next edge. After release: IDLE, cmd_ready=1, no response.
- Saturation, TIMEOUT_CNT_WIDTH=2: 5 consecutive timeouts -> timeout_count sequence 1,2,3,3,3.
